// File: rtl/msu_host_driver_pkg.sv
// Shared types, error bit positions and packet sizing helpers for the msu
// host driver. The count functions are the single source of packet sizes so
// the driver and the msu block cannot disagree on beat counts.
package msu_host_driver_pkg;

  // Operand widths of the modular squaring datapath.
  localparam int DAT_BITS = 64;
  localparam int TOT_BITS = 96;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_RECV,
    ST_WAIT_DONE,
    ST_RESP
  } msu_drv_state_t;

  localparam int ERR_TLAST_EARLY   = 0;
  localparam int ERR_TLAST_MISSING = 1;
  localparam int ERR_TIMEOUT       = 2;
  localparam int ERR_SIZE          = 3;

  // Beats in the msu input packet: t_start, t_final, then sq_in.
  function automatic int msu_in_count(input int axi_len, input int t_len,
                                      input int sq_in_bits);
    return (2 * t_len) / axi_len + sq_in_bits / axi_len;
  endfunction

  // Beats in the msu output packet: t_current, then sq_out.
  function automatic int msu_out_count(input int axi_len, input int t_len,
                                       input int sq_out_bits);
    return t_len / axi_len + sq_out_bits / axi_len;
  endfunction

endpackage

// File: rtl/msu_host_driver_if.sv
// AXI-stream bundle used for both directions between the driver and the msu.
interface msu_host_driver_if #(
  parameter int AXI_LEN = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [AXI_LEN-1:0]     tdata;
  logic [AXI_LEN/8-1:0]   tkeep;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast,
                  input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast,
                  output tready);
endinterface

// File: rtl/msu_host_driver_axis_shift_ser.sv
// Right-shifting stream serialiser: a wide word is loaded in one cycle and
// handed out least-significant word first, one word per accepted beat.
module axis_shift_ser #(
  parameter int WORD_W = 32,
  parameter int COUNT  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [WORD_W*COUNT-1:0]  load_data,
  input  logic                     fire,
  output logic [WORD_W-1:0]        word,
  output logic                     last,
  output logic                     first
);

  localparam int DATA_W = WORD_W * COUNT;
  localparam int BEAT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [DATA_W-1:0] shreg;
  logic [BEAT_W-1:0] beat;

  // Load the packet, then drop one word per handshake and wrap the beat count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      beat  <= '0;
    end else if (load) begin
      shreg <= load_data;
      beat  <= '0;
    end else if (fire) begin
      shreg <= shreg >> WORD_W;
      beat  <= last ? '0 : beat + 1'b1;
    end
  end

  assign word  = shreg[WORD_W-1:0];
  assign last  = (beat == BEAT_W'(COUNT - 1));
  assign first = (beat == '0);

endmodule

// File: rtl/msu_host_driver.sv
// Drives one squaring job through the msu: accepts a command, starts the msu,
// streams the command packet out, collects the result packet, waits for
// ap_done and offers the result with any error flags on a response handshake.
module msu_host_driver
  import msu_host_driver_pkg::*;
#(
  parameter int AXI_LEN           = 32,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int T_LEN             = 64,
  parameter int SQ_IN_BITS        = DAT_BITS,
  parameter int SQ_OUT_BITS       = TOT_BITS,
  parameter int TIMEOUT_CYCLES    = 2**24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [T_LEN-1:0]              cmd_t_start,
  input  logic [T_LEN-1:0]              cmd_t_final,
  input  logic [SQ_IN_BITS-1:0]         cmd_sq_in,
  output logic                          ap_start,
  input  logic                          ap_done,
  msu_host_driver_if.master             m_axis,
  msu_host_driver_if.slave              s_axis,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  msu_in_xfer_bytes,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  msu_out_xfer_bytes,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [T_LEN-1:0]              rsp_t_current,
  output logic [SQ_OUT_BITS-1:0]        rsp_sq_out,
  output logic [3:0]                    rsp_err,
  output logic                          busy
);

  localparam int IN_COUNT  = msu_in_count(AXI_LEN, T_LEN, SQ_IN_BITS);
  localparam int OUT_COUNT = msu_out_count(AXI_LEN, T_LEN, SQ_OUT_BITS);
  localparam int RX_W      = OUT_COUNT * AXI_LEN;
  localparam int RX_BW     = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam int WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IN_BYTES  = IN_COUNT * AXI_LEN / 8;
  localparam int OUT_BYTES = OUT_COUNT * AXI_LEN / 8;

  // Packets are built from whole stream words only.
  if ((T_LEN % AXI_LEN) != 0 || (SQ_IN_BITS % AXI_LEN) != 0 ||
      (SQ_OUT_BITS % AXI_LEN) != 0) begin : g_width_check
    $error("msu_host_driver: T_LEN, SQ_IN_BITS and SQ_OUT_BITS must be multiples of AXI_LEN");
  end

  msu_drv_state_t     state;
  msu_drv_state_t     state_next;
  logic [RX_W-1:0]    rx;
  logic [RX_BW-1:0]   rx_beat;
  logic [WD_W-1:0]    wd_cnt;
  logic               done_flag;
  logic [3:0]         err;
  logic               cmd_fire;
  logic               tx_valid;
  logic               tx_fire;
  logic               tx_last;
  logic               tx_first;
  logic [AXI_LEN-1:0] tx_word;
  logic               rx_ready;
  logic               rx_fire;
  logic               rx_last_beat;
  logic               wd_expired;
  logic               timeout_now;
  logic               size_mismatch;

  axis_shift_ser #(
    .WORD_W (AXI_LEN),
    .COUNT  (IN_COUNT)
  ) u_tx_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (cmd_fire),
    .load_data ({cmd_sq_in, cmd_t_final, cmd_t_start}),
    .fire      (tx_fire),
    .word      (tx_word),
    .last      (tx_last),
    .first     (tx_first)
  );

  assign cmd_fire      = cmd_valid && cmd_ready;
  assign tx_fire       = tx_valid && m_axis.tready;
  assign rx_fire       = rx_ready && s_axis.tvalid;
  assign rx_last_beat  = (rx_beat == RX_BW'(OUT_COUNT - 1));
  assign wd_expired    = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign size_mismatch = (msu_in_xfer_bytes  != C_XFER_SIZE_WIDTH'(IN_BYTES)) ||
                         (msu_out_xfer_bytes != C_XFER_SIZE_WIDTH'(OUT_BYTES));

  assign m_axis.tvalid = tx_valid;
  assign m_axis.tdata  = tx_word;
  assign m_axis.tkeep  = '1;
  assign m_axis.tlast  = tx_valid && tx_last;
  assign s_axis.tready = rx_ready;
  assign rsp_err       = err;

  // Next-state and handshake outputs; forward progress wins over the watchdog.
  always_comb begin
    state_next  = state;
    timeout_now = 1'b0;
    cmd_ready   = 1'b0;
    tx_valid    = 1'b0;
    ap_start    = 1'b0;
    rx_ready    = 1'b0;
    rsp_valid   = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        ap_start = tx_first;
        if (tx_fire && tx_last) begin
          state_next = ST_RECV;
        end else if (wd_expired) begin
          timeout_now = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_RECV: begin
        rx_ready = 1'b1;
        if (rx_fire && (s_axis.tlast || rx_last_beat)) begin
          state_next = ST_WAIT_DONE;
        end else if (wd_expired) begin
          timeout_now = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_WAIT_DONE: begin
        if (ap_done || done_flag) begin
          state_next = ST_RESP;
        end else if (wd_expired) begin
          timeout_now = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, receive shifter, watchdog, error flags and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      rx            <= '0;
      rx_beat       <= '0;
      wd_cnt        <= '0;
      done_flag     <= 1'b0;
      err           <= '0;
      rsp_t_current <= '0;
      rsp_sq_out    <= '0;
    end else begin
      state <= state_next;

      if (state_next != state) begin
        wd_cnt <= '0;
      end else if ((state == ST_SEND || state == ST_RECV ||
                    state == ST_WAIT_DONE) && !wd_expired) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (timeout_now) err[ERR_TIMEOUT] <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            rx             <= '0;
            rx_beat        <= '0;
            done_flag      <= 1'b0;
            err            <= '0;
            err[ERR_SIZE]  <= size_mismatch;
          end
        end
        ST_RECV: begin
          if (ap_done) done_flag <= 1'b1;
          if (rx_fire) begin
            rx      <= {s_axis.tdata, rx[RX_W-1:AXI_LEN]};
            rx_beat <= rx_beat + 1'b1;
            if (s_axis.tlast && !rx_last_beat) err[ERR_TLAST_EARLY] <= 1'b1;
            if (!s_axis.tlast && rx_last_beat) err[ERR_TLAST_MISSING] <= 1'b1;
          end
        end
        default: ;
      endcase

      if (state_next == ST_RESP && state != ST_RESP) begin
        rsp_t_current <= rx[T_LEN-1:0];
        rsp_sq_out    <= rx[RX_W-1:T_LEN];
      end
    end
  end

endmodule

// File: tb/tb_msu_host_driver.sv
// Scoreboard bench for msu_host_driver: expected stream words and responses
// are queued by the stimulus, and independent monitors pop and compare them.
module tb_msu_host_driver;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } tx_exp_t;

  typedef struct {
    logic [63:0] t;
    logic [95:0] sq;
    logic [3:0]  err;
    bit          chk_data;
  } rsp_exp_t;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_t_start;
  logic [63:0] cmd_t_final;
  logic [63:0] cmd_sq_in;
  logic        ap_start;
  logic        ap_done;
  logic [31:0] msu_in_xfer_bytes;
  logic [31:0] msu_out_xfer_bytes;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_t_current;
  logic [95:0] rsp_sq_out;
  logic [3:0]  rsp_err;
  logic        busy;

  msu_host_driver_if #(.AXI_LEN(32)) m_axis ();
  msu_host_driver_if #(.AXI_LEN(32)) s_axis ();

  msu_host_driver #(
    .AXI_LEN           (32),
    .C_XFER_SIZE_WIDTH (32),
    .T_LEN             (64),
    .SQ_IN_BITS        (64),
    .SQ_OUT_BITS       (96),
    .TIMEOUT_CYCLES    (100)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_t_start        (cmd_t_start),
    .cmd_t_final        (cmd_t_final),
    .cmd_sq_in          (cmd_sq_in),
    .ap_start           (ap_start),
    .ap_done            (ap_done),
    .m_axis             (m_axis),
    .s_axis             (s_axis),
    .msu_in_xfer_bytes  (msu_in_xfer_bytes),
    .msu_out_xfer_bytes (msu_out_xfer_bytes),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_t_current      (rsp_t_current),
    .rsp_sq_out         (rsp_sq_out),
    .rsp_err            (rsp_err),
    .busy               (busy)
  );

  int          tests;
  int          failed;
  tx_exp_t     tx_q[$];
  rsp_exp_t    rsp_q[$];
  tx_exp_t     tx_e;
  rsp_exp_t    rsp_e;
  int          tx_beat;
  bit          stalled;
  logic [31:0] held_data;
  logic [31:0] rx_words[5] = '{32'd7, 32'd0, 32'hA, 32'hB, 32'hC};

  localparam logic [63:0] EXP_T  = 64'd7;
  localparam logic [95:0] EXP_SQ = 96'h0000000C_0000000B_0000000A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Stream monitor: ap_start, beat order/content, tlast and stall stability.
  always @(negedge clk) begin
    if (!reset && m_axis.tvalid) begin
      checkOutput("ap_start", ap_start, (tx_beat == 0));
      if (m_axis.tready) begin
        if (tx_q.size() == 0) begin
          checkOutput("tx_unexpected_beat", 1'b1, 1'b0);
        end else begin
          tx_e = tx_q.pop_front();
          checkOutput("tx_tdata", m_axis.tdata, tx_e.data);
          checkOutput("tx_tlast", m_axis.tlast, tx_e.last);
          checkOutput("tx_tkeep", m_axis.tkeep, 4'hF);
          tx_beat = tx_e.last ? 0 : tx_beat + 1;
        end
        stalled = 1'b0;
      end else begin
        if (stalled) checkOutput("tx_tdata_stable", m_axis.tdata, held_data);
        stalled   = 1'b1;
        held_data = m_axis.tdata;
      end
    end
  end

  // Response monitor: compares each accepted result with the queued one.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        checkOutput("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        rsp_e = rsp_q.pop_front();
        checkOutput("rsp_err", rsp_err, rsp_e.err);
        if (rsp_e.chk_data) begin
          checkOutput("rsp_t_current", rsp_t_current, rsp_e.t);
          checkOutput("rsp_sq_out", rsp_sq_out, rsp_e.sq);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushTx(input logic [63:0] ts, tf, sq);
    tx_exp_t  te;
    logic [31:0] w[6];
    w[0] = ts[31:0];  w[1] = ts[63:32];
    w[2] = tf[31:0];  w[3] = tf[63:32];
    w[4] = sq[31:0];  w[5] = sq[63:32];
    for (int i = 0; i < 6; i++) begin
      te.data = w[i];
      te.last = (i == 5);
      tx_q.push_back(te);
    end
  endtask

  task automatic issueCmd(input logic [63:0] ts, tf, sq);
    int t;
    cmd_t_start = ts;
    cmd_t_final = tf;
    cmd_sq_in   = sq;
    cmd_valid   = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      waitCycles(1);
      t++;
    end
    if (t >= 50) checkOutput("cmd_accept_wait", 1'b0, 1'b1);
    waitCycles(1);
    cmd_valid = 1'b0;
    checkOutput("first_beat_latency", m_axis.tvalid, 1'b1);
  endtask

  // done_mode: 0 never, 1 one cycle after the last beat, 2 with the last beat.
  task automatic applyStimulus(input logic [63:0] ts, tf, sq, input int gap,
                               input int n_words, input int tlast_at,
                               input int done_mode, input logic [3:0] exp_err,
                               input bit chk_data);
    rsp_exp_t re;
    int t;
    pushTx(ts, tf, sq);
    re.t = EXP_T; re.sq = EXP_SQ; re.err = exp_err; re.chk_data = chk_data;
    rsp_q.push_back(re);
    issueCmd(ts, tf, sq);

    for (int i = 0; i < 6; i++) begin
      m_axis.tready = 1'b0;
      waitCycles($urandom_range(0, gap));
      m_axis.tready = 1'b1;
      t = 0;
      while (!m_axis.tvalid && t < 50) begin
        waitCycles(1);
        t++;
      end
      if (t >= 50) checkOutput("tx_wait", 1'b0, 1'b1);
      waitCycles(1);
    end
    m_axis.tready = 1'b0;

    for (int i = 0; i < n_words; i++) begin
      s_axis.tvalid = 1'b0;
      waitCycles($urandom_range(0, gap));
      s_axis.tdata = rx_words[i];
      s_axis.tlast = (i + 1 == tlast_at);
      if (done_mode == 2 && i == n_words - 1) ap_done = 1'b1;
      s_axis.tvalid = 1'b1;
      t = 0;
      while (!s_axis.tready && t < 50) begin
        waitCycles(1);
        t++;
      end
      if (t >= 50) checkOutput("rx_wait", 1'b0, 1'b1);
      waitCycles(1);
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      ap_done       = 1'b0;
    end

    if (done_mode == 1) begin
      waitCycles(1);
      ap_done = 1'b1;
      waitCycles(1);
      ap_done = 1'b0;
      checkOutput("rsp_after_done", rsp_valid, 1'b1);
    end else if (done_mode == 2) begin
      waitCycles(1);
      checkOutput("rsp_after_sticky_done", rsp_valid, 1'b1);
    end else begin
      t = 0;
      while (!rsp_valid && t < 300) begin
        waitCycles(1);
        t++;
      end
      checkOutput("timeout_latency", (t >= 99 && t <= 101), 1'b1);
    end

    t = 0;
    while (!rsp_valid && t < 300) begin
      waitCycles(1);
      t++;
    end
    if (t >= 300) checkOutput("rsp_wait", 1'b0, 1'b1);
    waitCycles(2);
    checkOutput("rsp_valid_held", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    waitCycles(1);
    rsp_ready = 1'b0;
    checkOutput("err_hold_idle", rsp_err, exp_err);
    checkOutput("busy_idle", busy, 1'b0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ap_start", ap_start, 1'b0);
    checkOutput("rst_m_tvalid", m_axis.tvalid, 1'b0);
    checkOutput("rst_m_tlast", m_axis.tlast, 1'b0);
    checkOutput("rst_s_tready", s_axis.tready, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_err", rsp_err, 4'h0);
  endtask

  // Abandon a job after three input beats with an asynchronous reset.
  task automatic resetMidSend();
    int t;
    pushTx(64'd9, 64'd11, 64'hAAAA_BBBB_CCCC_DDDD);
    issueCmd(64'd9, 64'd11, 64'hAAAA_BBBB_CCCC_DDDD);
    m_axis.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (!m_axis.tvalid && t < 50) begin
        waitCycles(1);
        t++;
      end
      waitCycles(1);
    end
    m_axis.tready = 1'b0;
    checkOutput("beats_before_reset", tx_q.size(), 3);
    #2 reset = 1'b1;
    #1;
    checkResetOutputs();
    tx_q.delete();
    tx_beat = 0;
    stalled = 1'b0;
    waitCycles(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    tests = 0; failed = 0; tx_beat = 0; stalled = 1'b0; held_data = '0;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_t_start = '0; cmd_t_final = '0; cmd_sq_in = '0;
    ap_done = 1'b0; rsp_ready = 1'b0;
    msu_in_xfer_bytes = 32'd24; msu_out_xfer_bytes = 32'd20;
    m_axis.tready = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '1; s_axis.tlast = 1'b0;
    waitCycles(3);
    checkResetOutputs();
    reset = 1'b0;
    waitCycles(2);

    applyStimulus(64'd5, 64'd7, 64'h1122334455667788, 0, 5, 5, 1, 4'h0, 1'b1);
    applyStimulus(64'd5, 64'd7, 64'h1122334455667788, 5, 5, 5, 1, 4'h0, 1'b1);
    applyStimulus(64'h0000000100000002, 64'hFFFFFFFF00000003,
                  64'hDEADBEEFCAFEF00D, 3, 5, 5, 2, 4'h0, 1'b1);
    applyStimulus(64'd5, 64'd7, 64'h1122334455667788, 2, 3, 3, 1, 4'h1, 1'b0);
    applyStimulus(64'd5, 64'd7, 64'h1122334455667788, 2, 5, 0, 1, 4'h2, 1'b1);
    msu_in_xfer_bytes = 32'd20;
    applyStimulus(64'd1, 64'd2, 64'h0123456789ABCDEF, 1, 5, 5, 1, 4'h8, 1'b1);
    msu_in_xfer_bytes = 32'd24;
    applyStimulus(64'd5, 64'd7, 64'h1122334455667788, 0, 5, 5, 0, 4'h4, 1'b1);

    resetMidSend();
    applyStimulus(64'd3, 64'd4, 64'h5555666677778888, 1, 5, 5, 1, 4'h0, 1'b1);

    waitCycles(2);
    checkOutput("tx_q_empty", tx_q.size(), 0);
    checkOutput("rsp_q_empty", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
